// File: rtl/ram_pkg.sv
// Shared defaults, FSM state encoding and small helpers for the two-port RAM arbiter.
package ram_pkg;
  localparam int ADDR_W_DEF   = 12;
  localparam int DATA_W_DEF   = 8;
  localparam int MAX_HOLD_DEF = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_OWN0 = 2'd1;
  localparam logic [1:0] ST_OWN1 = 2'd2;

  function automatic logic [1:0] onehot2(input logic b);
    return b ? 2'b10 : 2'b01;
  endfunction
endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the pointer.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);
  always_comb begin
    gnt = req;
    if (&req) gnt = ptr ? 2'b10 : 2'b01;
  end
endmodule

// File: rtl/ram_arbiter.sv
// Arbitrates a core port and a host port onto one single-ported RAM.
// Supports locked read-modify-write bursts bounded by MAX_HOLD grants.
module ram_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int MAX_HOLD = MAX_HOLD_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic              ram_w_en,
  output logic              ram_r_en,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data_in,
  input  logic [DATA_W-1:0] ram_data_out
);
  localparam int CNT_W = $clog2(MAX_HOLD) + 1;
  localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

  logic [1:0]       state, state_nxt;
  logic             rr_ptr, ptr_nxt;
  logic [CNT_W-1:0] hold_cnt, cnt_nxt, cnt_inc;
  logic [1:0]       rd_tag;
  logic [1:0]       req, lock, we, pick_req, pick_gnt, gnt;
  logic             in_own, own, force_rel, gsel;

  assign req  = {req1, req0};
  assign lock = {lock1, lock0};
  assign we   = {we1, we0};

  assign in_own    = (state != ST_IDLE);
  assign own       = (state == ST_OWN1);
  assign force_rel = in_own && (hold_cnt == HOLD_MAX) && req[~own];

  // While owned, narrow the request set so the picker only sees the owner,
  // or only the other side once the owner has used up its hold budget.
  always_comb begin
    pick_req = req;
    if (in_own && req[own]) pick_req = force_rel ? onehot2(~own) : onehot2(own);
  end

  rr_pick2 u_pick (.req(pick_req), .ptr(rr_ptr), .gnt(pick_gnt));

  assign gnt  = rst ? 2'b00 : pick_gnt;
  assign gsel = gnt[1];
  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];

  assign ram_w_en    = (|gnt) &  we[gsel];
  assign ram_r_en    = (|gnt) & ~we[gsel];
  assign ram_address = gnt[1] ? addr1  : gnt[0] ? addr0  : '0;
  assign ram_data_in = gnt[1] ? wdata1 : gnt[0] ? wdata0 : '0;

  assign rvalid0 = rd_tag[0];
  assign rvalid1 = rd_tag[1];
  assign rdata   = ram_data_out;

  // hold_cnt counts locked grants in the current ownership, the entering one included.
  assign cnt_inc = (hold_cnt == HOLD_MAX) ? HOLD_MAX : hold_cnt + CNT_W'(1);

  always_comb begin
    state_nxt = state;
    ptr_nxt   = rr_ptr;
    cnt_nxt   = hold_cnt;
    if (|gnt) begin
      if (lock[gsel]) begin
        if (in_own && (gsel == own)) begin
          if ((cnt_inc == HOLD_MAX) && req[~own]) begin
            state_nxt = ST_IDLE;
            ptr_nxt   = ~own;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else begin
          state_nxt = gsel ? ST_OWN1 : ST_OWN0;
          cnt_nxt   = CNT_W'(1);
        end
      end else begin
        state_nxt = ST_IDLE;
        ptr_nxt   = ~gsel;
        cnt_nxt   = '0;
      end
    end else if (in_own && !req[own]) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      hold_cnt <= '0;
      rd_tag   <= 2'b00;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= ptr_nxt;
      hold_cnt <= cnt_nxt;
      rd_tag   <= gnt & ~we;
    end
  end
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios then random traffic against a transaction-level model.
module tb_ram_arbiter;
  localparam int AW = 12;
  localparam int DW = 8;
  localparam int MAXH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0, lock0 = 0, lock1 = 0;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic gnt0, gnt1, rvalid0, rvalid1, ram_w_en, ram_r_en;
  logic [DW-1:0] rdata, ram_data_in, ram_q;
  logic [AW-1:0] ram_address;

  always #5 clk = ~clk;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MAXH)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .lock0(lock0), .lock1(lock1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
    .ram_w_en(ram_w_en), .ram_r_en(ram_r_en), .ram_address(ram_address),
    .ram_data_in(ram_data_in), .ram_data_out(ram_q)
  );

  // environment RAM with 1-cycle registered read
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_w_en) ram[ram_address] <= ram_data_in;
    if (ram_r_en) ram_q <= ram[ram_address];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // reference model state
  int owner = -1, holds = 0, ptr = 0, last_g = -1;
  logic [1:0] pend = 2'b00;
  logic [DW-1:0] pend_data = '0;
  logic pend_known = 1'b0;
  logic [DW-1:0] mem_m [0:(1<<AW)-1];
  logic known [0:(1<<AW)-1];

  task automatic eval();
    int g;
    logic [1:0] rq, lk, wq;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    @(negedge clk);
    rq = {req1, req0}; lk = {lock1, lock0}; wq = {we1, we0};
    if (rst) begin
      chk("rst gnt", 32'({gnt1, gnt0}), 32'(0));
      chk("rst rvalid", 32'({rvalid1, rvalid0}), 32'(0));
      chk("rst strobes", 32'({ram_w_en, ram_r_en}), 32'(0));
      chk("rst addr", 32'(ram_address), 32'(0));
      chk("rst wdata", 32'(ram_data_in), 32'(0));
      owner = -1; holds = 0; ptr = 0; pend = 2'b00; last_g = -1;
      return;
    end
    chk("rvalid0", 32'(rvalid0), 32'(pend[0]));
    chk("rvalid1", 32'(rvalid1), 32'(pend[1]));
    if (pend != 2'b00 && pend_known) chk("rdata", 32'(rdata), 32'(pend_data));
    // owner keeps the RAM unless it has used its budget and the other side waits
    if (owner >= 0 && rq[owner]) g = (holds >= MAXH && rq[1-owner]) ? 1 - owner : owner;
    else if (rq == 2'b11) g = ptr;
    else if (rq[0]) g = 0;
    else if (rq[1]) g = 1;
    else g = -1;
    ea = (g == 0) ? addr0 : (g == 1) ? addr1 : '0;
    ed = (g == 0) ? wdata0 : (g == 1) ? wdata1 : '0;
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("ram_w_en", 32'(ram_w_en), 32'(g >= 0 && wq[g]));
    chk("ram_r_en", 32'(ram_r_en), 32'(g >= 0 && !wq[g]));
    chk("ram_address", 32'(ram_address), 32'(ea));
    chk("ram_data_in", 32'(ram_data_in), 32'(ed));
    pend = 2'b00;
    if (g >= 0) begin
      if (wq[g]) begin
        mem_m[ea] = ed; known[ea] = 1'b1;
      end else begin
        pend[g] = 1'b1; pend_data = mem_m[ea]; pend_known = known[ea];
      end
      if (lk[g]) begin
        if (owner == g) begin
          holds = (holds + 1 > MAXH) ? MAXH : holds + 1;
          if (holds == MAXH && rq[1-g]) begin owner = -1; holds = 0; ptr = 1 - g; end
        end else begin
          owner = g; holds = 1;
        end
      end else begin
        owner = -1; holds = 0; ptr = 1 - g;
      end
    end else if (owner >= 0 && !rq[owner]) begin
      owner = -1; holds = 0;
    end
    last_g = g;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_in();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
  endtask

  task automatic do_reset();
    clear_in(); rst = 1; eval(); tick(); rst = 0;
  endtask

  logic [1:0] act = 2'b00, lmode = 2'b00;

  task automatic new_req(input int n);
    logic w, l;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    w = $urandom_range(0, 1) == 1;
    a = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    d = DW'($urandom);
    l = lmode[n];
    if (n == 0) begin req0 = 1; we0 = w; addr0 = a; wdata0 = d; lock0 = l; end
    else        begin req1 = 1; we1 = w; addr1 = a; wdata1 = d; lock1 = l; end
    act[n] = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) begin mem_m[i] = '0; known[i] = 1'b0; end
    #1;
    rst = 1; eval(); tick(); eval(); tick(); rst = 0;

    // write then read back on port 0
    req0 = 1; we0 = 1; addr0 = 12'h010; wdata0 = 8'hA5;
    eval();
    chk("d35 gnt0", 32'(gnt0), 32'(1));
    chk("d35 w_en", 32'(ram_w_en), 32'(1));
    chk("d35 addr", 32'(ram_address), 32'h010);
    chk("d35 data", 32'(ram_data_in), 32'hA5);
    tick();
    we0 = 0; eval(); tick();
    req0 = 0; eval();
    chk("d36 rvalid0", 32'(rvalid0), 32'(1));
    chk("d36 rdata", 32'(rdata), 32'hA5);
    chk("d36 rvalid1", 32'(rvalid1), 32'(0));
    tick();

    // both reading continuously alternate
    do_reset();
    req0 = 1; req1 = 1; addr0 = 12'h001; addr1 = 12'h002;
    for (int i = 0; i < 8; i++) begin
      eval(); chk("d37 alt", 32'(gnt1), 32'(i % 2)); tick();
    end
    clear_in();

    // locked host burst is cut after MAX_HOLD grants
    do_reset();
    req1 = 1; lock1 = 1; addr1 = 12'h005;
    eval(); chk("d38 first", 32'(gnt1), 32'(1)); tick();
    req0 = 1; addr0 = 12'h006;
    for (int i = 2; i <= MAXH; i++) begin
      eval(); chk("d38 hold", 32'(gnt1), 32'(1)); tick();
    end
    eval();
    chk("d38 release gnt0", 32'(gnt0), 32'(1));
    chk("d38 release gnt1", 32'(gnt1), 32'(0));
    tick(); clear_in();

    // reset during a locked read abandons it
    do_reset();
    req0 = 1; lock0 = 1; addr0 = 12'h007;
    eval(); tick();
    rst = 1;
    eval();
    chk("d39 gnt0", 32'(gnt0), 32'(0));
    chk("d39 rvalid0", 32'(rvalid0), 32'(0));
    tick();
    rst = 0; clear_in();
    eval(); chk("d39 no rvalid", 32'(rvalid0), 32'(0)); tick();
    req0 = 1; req1 = 1; addr0 = 12'h008; addr1 = 12'h009;
    eval(); chk("d39 first gnt0", 32'(gnt0), 32'(1)); tick();
    clear_in();

    // pointer now names port 1: write by 1 precedes read by 0
    req1 = 1; we1 = 1; addr1 = 12'hFFF; wdata1 = 8'h3C;
    req0 = 1; we0 = 0; addr0 = 12'hFFF;
    eval();
    chk("d40 gnt1", 32'(gnt1), 32'(1));
    chk("d40 gnt0 wait", 32'(gnt0), 32'(0));
    tick(); req1 = 0; we1 = 0;
    eval(); chk("d40 gnt0", 32'(gnt0), 32'(1)); tick();
    req0 = 0;
    eval();
    chk("d40 rvalid0", 32'(rvalid0), 32'(1));
    chk("d40 rdata", 32'(rdata), 32'h3C);
    tick();

    // random traffic
    clear_in(); act = 2'b00; last_g = -1;
    for (int c = 0; c < 4000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if ($urandom_range(0, 39) == 0) lmode[n] = ~lmode[n];
        if (last_g == n) begin
          act[n] = 1'b0;
          if (n == 0) req0 = 0; else req1 = 0;
        end
        if (!act[n] && (lmode[n] || $urandom_range(0, 9) < 5)) new_req(n);
      end
      rst = ($urandom_range(0, 299) == 0);
      eval();
      tick();
    end
    clear_in(); rst = 0;
    eval(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_W, 12, RAM address width (4096 words).
REQ-002 Parameter DATA_W, 8, RAM word width (one pixel).
REQ-003 Parameter MAX_HOLD, 16, maximum consecutive locked grants before forced release.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 req0/req1  in  1 each  access request, requester 0 = processor core, 1 = host load/dump port.
REQ-007 we0/we1  in  1 each  1 = write, 0 = read; qualified by reqN.
REQ-008 lock0/lock1  in  1 each  hold grant on following cycle (read-modify-write sequences).
REQ-009 addr0/addr1  in  ADDR_W each  word address.
REQ-010 wdata0/wdata1  in  DATA_W each  write data.
REQ-011 gnt0/gnt1  out  1 each  request accepted this cycle.
REQ-012 rvalid0/rvalid1  out  1 each  read data valid for that requester.
REQ-013 rdata  out  DATA_W  read data, shared by both requesters, qualified by rvalidN.
REQ-014 ram_w_en, ram_r_en  out  1 each  RAM write/read strobes.
REQ-015 ram_address  out  ADDR_W; ram_data_in  out  DATA_W  RAM command.
REQ-016 ram_data_out  in  DATA_W  RAM registered read data (1-cycle latency).

Function
REQ-017 At most one of gnt0/gnt1 SHALL be high in any cycle; gnt is combinational from req, owner state, rr pointer.
REQ-018 A request SHALL complete in the cycle its gnt is high; requester holds req/we/addr/wdata stable until granted.
REQ-019 Arbitration SHALL be round-robin: rr pointer names priority requester; after any unlocked grant, pointer moves to the other requester.
REQ-020 Lone requester SHALL be granted the same cycle (zero-wait) regardless of pointer.
REQ-021 Granted requester's addr/wdata SHALL drive ram_address/ram_data_in; ram_w_en = gnt & we; ram_r_en = gnt & ~we; with no grant both strobes 0 and address/data hold 0.
REQ-022 rvalidN SHALL assert exactly one cycle after a granted read by N, for one cycle; rdata = ram_data_out.
REQ-023 FSM states IDLE, OWN0, OWN1: grant with lockN=1 enters/stays OWNN; in OWNN only N is granted while reqN=1.
REQ-024 OWNN SHALL exit to IDLE when reqN=0, lockN=0 on a grant, or hold counter reaches MAX_HOLD while other requester asserts req.
REQ-025 Hold counter (width clog2(MAX_HOLD)+1) SHALL clear on entering OWNN, increment per locked grant, saturate at MAX_HOLD.
REQ-026 Forced release SHALL set rr pointer to the other requester; that requester is granted next cycle.
REQ-027 Simultaneous req0/req1 in IDLE SHALL grant pointer-named requester; other waits one cycle minimum.
REQ-028 Write and read to same address by different requesters in consecutive cycles SHALL be ordered by grant order (read after write returns new data).

Reset
REQ-029 While rst=1: gnt0/gnt1, rvalid0/rvalid1, ram_w_en, ram_r_en = 0; ram_address, ram_data_in = 0.
REQ-030 Reset SHALL set state IDLE, rr pointer = requester 0, hold counter = 0, pending-read tags cleared.
REQ-031 Reset mid-lock or mid-read SHALL abandon the operation; no rvalid issued after reset release for pre-reset reads.

Structure
REQ-032 ADDR_W, DATA_W defaults and FSM state encoding SHALL live in shared package ram_pkg.
REQ-033 Round-robin selection SHALL be sub-module rr_pick2 (inputs req pair, pointer; output one-hot grant).
REQ-034 Target size 120-400 RTL lines; no RAM storage inside this block.

Verification
REQ-035 Reset, then req0 write addr 0x010 data 0xA5 -> gnt0 same cycle, ram_w_en=1, ram_address=0x010, ram_data_in=0xA5.
REQ-036 req0 read 0x010 following -> rvalid0 next cycle, rdata=0xA5, rvalid1 stays 0.
REQ-037 req0 and req1 both reading every cycle from reset -> grants alternate 0,1,0,1; no starvation.
REQ-038 req1 with lock1=1 continuously, req0 waiting -> 16 consecutive gnt1, then gnt0 on cycle 17.
REQ-039 rst asserted during OWN0 with read in flight -> outputs 0 immediately; after release no rvalid0; first simultaneous request grants requester 0.
REQ-040 req1 write 0xFFF data 0x3C, req0 read 0xFFF same cycle (pointer=1) -> gnt1 then gnt0; rvalid0 returns 0x3C.
